// File: rtl/alu_4.sv
// alu_4: registered 4-bit ALU with an 8-bit result.
// Operands are zero-extended to 8 bits, so sums, differences and products
// fit in the output. The result appears on OUT one clock after the inputs
// are sampled.
// Optional feature macro: ALU4_EXT_OPS_EN adds SHL (1001) and GT (1010).
// Without the macro, those two opcodes return 8'h00 like any other
// undefined opcode, and no shifter or comparator is built.
module alu_4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [3:0] CTRL,
  output logic [7:0] OUT
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_MUL  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_NAND = 4'h6,
    OP_NOR  = 4'h7,
    OP_XNOR = 4'h8,
    OP_SHL  = 4'h9,
    OP_GT   = 4'hA
  } op_e;

  op_e        op;
  logic [7:0] a_ext;
  logic [7:0] b_ext;
  logic [7:0] out_d;
  logic [7:0] out_q;

  assign op    = op_e'(CTRL);
  assign a_ext = {4'h0, A};
  assign b_ext = {4'h0, B};

  // Select the next result from the current operands and opcode.
  always_comb begin
    // NOTE: the default is assigned first so that every path drives out_d.
    // An opcode with no matching branch then yields 8'h00, and no latch is
    // inferred.
    out_d = 8'h00;
    case (op)
      OP_ADD:  out_d = a_ext + b_ext;
      OP_SUB:  out_d = a_ext - b_ext;   // wraps modulo 256 into two's complement
      OP_MUL:  out_d = a_ext * b_ext;   // 15 * 15 = 225 still fits in 8 bits
      OP_AND:  out_d = {4'h0, A & B};
      OP_OR:   out_d = {4'h0, A | B};
      OP_XOR:  out_d = {4'h0, A ^ B};
      OP_NAND: out_d = {4'h0, ~(A & B)};
      OP_NOR:  out_d = {4'h0, ~(A | B)};
      OP_XNOR: out_d = {4'h0, ~(A ^ B)};
`ifdef ALU4_EXT_OPS_EN
      OP_SHL:  out_d = a_ext << B[1:0];
      OP_GT:   out_d = (A > B) ? 8'h01 : 8'h00;
`endif
      default: out_d = 8'h00;
    endcase
  end

  // Result register; asynchronous reset clears OUT immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registers take non-blocking (<=) assignments so that every flop
    // samples pre-edge values, whatever order the processes are evaluated in.
    if (!rst_n) begin
      out_q <= 8'h00;
    end else begin
      out_q <= out_d;
    end
  end

  assign OUT = out_q;

endmodule

// File: tb/tb_alu_4.sv
// tb_alu_4: self-checking bench for alu_4.
// Each applied operation pushes its expected result onto a queue. The
// expected result is popped and compared one cycle later, on the falling
// edge of the clock.
module tb_alu_4;

  logic       clk;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] ctrl;
  logic [7:0] out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] ctrl;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } sb_t;

  sb_t sb_q[$];

  alu_4 dut (
    .clk  (clk),
    .rst_n(rst_n),
    .A    (a),
    .B    (b),
    .CTRL (ctrl),
    .OUT  (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ALU4_EXT_OPS_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 8'h%02h, expected 8'h%02h", name, act, exp);
    end
  endtask

  // Independent reference model, written from the opcode table.
  function automatic logic [7:0] ref_model(input logic [3:0] ra, input logic [3:0] rb,
                                           input logic [3:0] rc);
    int ia, ib, r;
    ia = int'(ra);
    ib = int'(rb);
    r  = 0;
    case (rc)
      4'd0: r = ia + ib;
      4'd1: r = (ia - ib + 256) % 256;
      4'd2: r = ia * ib;
      4'd3: r = ia & ib;
      4'd4: r = ia | ib;
      4'd5: r = ia ^ ib;
      4'd6: r = 15 - (ia & ib);
      4'd7: r = 15 - (ia | ib);
      4'd8: r = 15 - (ia ^ ib);
      4'd9: r = EXT ? ia * (1 << (ib % 4)) : 0;
      4'd10: r = (EXT && ia > ib) ? 1 : 0;
      default: r = 0;
    endcase
    return 8'(r);
  endfunction

  // Drive one operation (blocking) and record its expected result.
  task automatic issue(input string name, input logic [3:0] ia, input logic [3:0] ib,
                       input logic [3:0] ic, input logic [7:0] exp);
    sb_t e;
    a = ia; b = ib; ctrl = ic;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  // Advance to the next falling edge and compare the oldest pending result.
  task automatic retire();
    sb_t e;
    @(negedge clk);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.name, out, e.exp);
    end
  endtask

  vec_t vecs[$];

  initial begin
    // Directed vectors taken from the operation table.
    vecs.push_back('{"add",        4'h5, 4'hB, 4'h0, 8'h10});
    vecs.push_back('{"sub_neg",    4'h5, 4'hB, 4'h1, 8'hFA});
    vecs.push_back('{"mul",        4'h5, 4'hB, 4'h2, 8'h37});
    vecs.push_back('{"and",        4'h5, 4'hB, 4'h3, 8'h01});
    vecs.push_back('{"or",         4'h5, 4'hB, 4'h4, 8'h0F});
    vecs.push_back('{"xor",        4'h5, 4'hB, 4'h5, 8'h0E});
    vecs.push_back('{"nand",       4'h5, 4'hB, 4'h6, 8'h0E});
    vecs.push_back('{"nor",        4'h5, 4'hB, 4'h7, 8'h00});
    vecs.push_back('{"xnor",       4'h5, 4'hB, 4'h8, 8'h01});
    vecs.push_back('{"add_max",    4'hF, 4'hF, 4'h0, 8'h1E});
    vecs.push_back('{"mul_max",    4'hF, 4'hF, 4'h2, 8'hE1});
    vecs.push_back('{"sub_0_15",   4'h0, 4'hF, 4'h1, 8'hF1});
    vecs.push_back('{"sub_pos",    4'hB, 4'h5, 4'h1, 8'h06});
    vecs.push_back('{"nor_zero",   4'h0, 4'h0, 4'h7, 8'h0F});
    vecs.push_back('{"gt_1_0",     4'h1, 4'h0, 4'hA, EXT ? 8'h01 : 8'h00});
    vecs.push_back('{"gt_equal",   4'h7, 4'h7, 4'hA, 8'h00});
    vecs.push_back('{"gt_less",    4'h2, 4'h9, 4'hA, 8'h00});
    vecs.push_back('{"shl_5_2",    4'h5, 4'h2, 4'h9, EXT ? 8'h14 : 8'h00});
    vecs.push_back('{"shl_f_7",    4'hF, 4'h7, 4'h9, EXT ? 8'h78 : 8'h00});
    vecs.push_back('{"undef_b",    4'hF, 4'hF, 4'hB, 8'h00});
    vecs.push_back('{"undef_f",    4'hF, 4'hF, 4'hF, 8'h00});

    rst_n = 1'b0;
    a = 4'h0; b = 4'h0; ctrl = 4'h0;
    #1;
    check("reset_state", out, 8'h00);

    // Release reset away from a clock edge.
    @(negedge clk);
    rst_n = 1'b1;

    // Apply the table back to back, one operation per cycle.
    foreach (vecs[i]) begin
      issue(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].ctrl, vecs[i].exp);
      retire();
    end

    // Consecutive ADD, SUB and MUL issues.
    issue("b2b_add", 4'h3, 4'h4, 4'h0, 8'h07);
    retire();
    issue("b2b_sub", 4'h3, 4'h4, 4'h1, 8'hFF);
    retire();
    issue("b2b_mul", 4'h3, 4'h4, 4'h2, 8'h0C);
    retire();

    // Inputs that change between edges must not affect OUT.
    issue("hold_mid", 4'h9, 4'h9, 4'h2, 8'h51);
    @(posedge clk);
    #2;
    a = 4'h1; b = 4'h1; ctrl = 4'h0;
    #1;
    check("mid_cycle_change_0", out, 8'h51);
    #2;
    check("mid_cycle_change_1", out, 8'h51);
    void'(sb_q.pop_front());

    // Mid-cycle reset with OUT non-zero: OUT must clear before any clock edge.
    @(negedge clk);
    a = 4'hF; b = 4'hF; ctrl = 4'h0;
    @(posedge clk);
    #2;
    check("pre_reset_nonzero", out, 8'h1E);
    rst_n = 1'b0;
    #1;
    check("async_reset_clear", out, 8'h00);
    @(posedge clk);
    #1;
    check("reset_held_over_edge", out, 8'h00);
    // Release just after an edge; OUT stays 0 until the next rising edge.
    #1;
    rst_n = 1'b1;
    #2;
    check("after_release_before_edge", out, 8'h00);
    @(posedge clk);
    #1;
    check("first_edge_after_release", out, 8'h1E);

    // Reset asserted in the same timestep as a rising edge wins.
    @(negedge clk);
    a = 4'h7; b = 4'h3; ctrl = 4'h2;
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    check("reset_at_edge", out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.delete();

    // Randomised operations checked against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [3:0] ra, rb, rc;
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rc = 4'($urandom_range(0, 15));
      issue($sformatf("rand_%0d_op%0h", i, rc), ra, rb, rc, ref_model(ra, rb, rc));
      retire();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
